// File: rtl/int_alu_pkg.sv
// int_alu_pkg: op codes, FSM state codes and latencies for int_alu_mc.
// Shared by the ALU top and its divider core.
package int_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_MOD  = 3'd4,
    OP_SMUL = 3'd5,
    OP_SDIV = 3'd6,
    OP_SMOD = 3'd7
  } op_e;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_DIV  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_PRE  = 3'd5;
  localparam logic [2:0] ST_POST = 3'd6;

  localparam int LAT_ADD = 1;

  function automatic int LAT_MUL(input int w);
    return w + 1;
  endfunction

  function automatic int LAT_DIV(input int w);
    return w + 1;
  endfunction

  function automatic logic is_udiv(input op_e o);
    return (o == OP_DIV) || (o == OP_MOD);
  endfunction

  function automatic logic is_sgn(input op_e o);
    return (o == OP_SMUL) || (o == OP_SDIV) || (o == OP_SMOD);
  endfunction

endpackage

// File: rtl/int_alu_divmod_core.sv
// int_alu_divmod_core: restoring 2W/W divider, one quotient bit per cycle.
// Flags divide-by-zero and quotient overflow at start and skips iterating.
module int_alu_divmod_core
  import int_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           done,
  output logic [W-1:0]   quo,
  output logic [W-1:0]   rem,
  output logic           div0,
  output logic           ovf
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(W);

  logic [W-1:0]     rem_q;
  logic [W-1:0]     quo_q;
  logic [W-1:0]     dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             div0_q;
  logic             ovf_q;
  logic [W:0]       trial;

  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dsr_q};
  assign done  = run_q && (div0_q || ovf_q || (cnt_q == CNT_END));
  assign quo   = quo_q;
  assign rem   = rem_q;
  assign div0  = div0_q;
  assign ovf   = ovf_q;

  // load on start, then shift/subtract one bit per cycle until done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      rem_q  <= dividend[2*W-1:W];
      quo_q  <= dividend[W-1:0];
      dsr_q  <= divisor;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      div0_q <= (divisor == '0);
      ovf_q  <= (divisor != '0) &&
                (dividend[2*W-1:W] >= divisor);
    end else if (run_q) begin
      if (done) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (!trial[W]) begin
          rem_q <= trial[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[W-2:0], quo_q[W-1]};
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/int_alu_mc.sv
// int_alu_mc: multi-cycle integer ALU (add/sub, shift-add mul, div/mod).
// INT_ALU_SIGNED_EN enables SMUL/SDIV/SMOD; otherwise ops 5-7 are illegal.
module int_alu_mc
  import int_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] res,
  output logic           co,
  output logic           cy,
  output logic           err
);

  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(W);

  logic [2:0]       state;
  op_e              op_r;
  op_e              op_in;
  logic [W-1:0]     a_lo_r;
  logic [W-1:0]     b_r;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplr;
  logic [2*W-1:0]   res_r;
  logic             co_r;
  logic             cy_r;
  logic             err_r;
  logic             accept;
  logic             post_needed;

  logic             sub;
  logic [W-1:0]     b_eff;
  logic [W:0]       sum;
  logic             ovf_as;

  logic             core_start;
  logic             core_done;
  logic             core_div0;
  logic             core_ovf;
  logic [2*W-1:0]   core_a;
  logic [W-1:0]     core_b;
  logic [W-1:0]     core_quo;
  logic [W-1:0]     core_rem;
  logic [2*W-1:0]   div_res;

  assign op_in     = op_e'(op);
  assign accept    = in_valid && (state == ST_IDLE);
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign res       = res_r;
  assign co        = co_r;
  assign cy        = cy_r;
  assign err       = err_r;

  assign sub    = (op_r == OP_SUB);
  assign b_eff  = sub ? ~b_r : b_r;
  assign sum    = {1'b0, a_lo_r} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  assign ovf_as = (a_lo_r[W-1] == b_eff[W-1]) &&
                  (sum[W-1] != a_lo_r[W-1]);

`ifdef INT_ALU_SIGNED_EN
  logic [W-1:0]   a_hi_r;
  logic           neg_p;
  logic           neg_q;
  logic           neg_r;
  logic [2*W-1:0] a_full;
  logic [2*W-1:0] a_mag;
  logic [W-1:0]   alo_mag;
  logic [W-1:0]   b_mag;
  logic           q_range;
  logic [2*W-1:0] sgn_res;
  logic           sgn_err;

  assign a_full  = {a_hi_r, a_lo_r};
  assign a_mag   = a_hi_r[W-1] ? -a_full : a_full;
  assign alo_mag = a_lo_r[W-1] ? -a_lo_r : a_lo_r;
  assign b_mag   = b_r[W-1] ? -b_r : b_r;
  assign q_range = neg_q ? (core_quo > {1'b1, {(W-1){1'b0}}})
                         : core_quo[W-1];

  assign post_needed = is_sgn(op_r);
  assign core_start  = (accept && is_udiv(op_in)) ||
                       ((state == ST_PRE) && (op_r != OP_SMUL));
  assign core_a      = (state == ST_PRE) ? a_mag : a;
  assign core_b      = (state == ST_PRE) ? b_mag : b;

  // apply result signs to the unsigned core outputs
  always_comb begin
    sgn_res = '0;
    sgn_err = 1'b0;
    if (op_r == OP_SMUL) begin
      sgn_res = neg_p ? -acc : acc;
    end else if (core_div0 && (op_r == OP_SMOD)) begin
      sgn_err          = 1'b1;
      sgn_res[W-1:0]   = a_lo_r;
    end else if (core_div0 || core_ovf || q_range) begin
      sgn_err          = 1'b1;
      sgn_res[W-1:0]   = '1;
    end else if (op_r == OP_SDIV) begin
      sgn_res[W-1:0]   = neg_q ? -core_quo : core_quo;
    end else begin
      sgn_res[W-1:0]   = neg_r ? -core_rem : core_rem;
    end
  end
`else
  assign post_needed = 1'b0;
  assign core_start  = accept && is_udiv(op_in);
  assign core_a      = a;
  assign core_b      = b;
`endif

  // select unsigned DIV/MOD result, including error substitutes
  always_comb begin
    div_res = '0;
    if (core_div0 || core_ovf) begin
      div_res[W-1:0] = (op_r == OP_MOD) ? a_lo_r : '1;
    end else if (op_r == OP_MOD) begin
      div_res[W-1:0] = core_rem;
    end else begin
      div_res[W-1:0] = core_quo;
    end
  end

  int_alu_divmod_core #(.W(W)) u_divmod (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .dividend (core_a),
    .divisor  (core_b),
    .done     (core_done),
    .quo      (core_quo),
    .rem      (core_rem),
    .div0     (core_div0),
    .ovf      (core_ovf)
  );

  // FSM, operand capture, shift-add multiply and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_r   <= OP_ADD;
      a_lo_r <= '0;
      b_r    <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      res_r  <= '0;
      co_r   <= 1'b0;
      cy_r   <= 1'b0;
      err_r  <= 1'b0;
`ifdef INT_ALU_SIGNED_EN
      a_hi_r <= '0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_r   <= op_in;
            a_lo_r <= a[W-1:0];
            b_r    <= b;
`ifdef INT_ALU_SIGNED_EN
            a_hi_r <= a[2*W-1:W];
`endif
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a[W-1:0]};
            mplr   <= b;
            unique case (1'b1)
              op_in == OP_MUL: state <= ST_MUL;
              is_udiv(op_in):  state <= ST_DIV;
`ifdef INT_ALU_SIGNED_EN
              is_sgn(op_in):   state <= ST_PRE;
`endif
              default:         state <= ST_EXEC;
            endcase
          end
        end
        ST_EXEC: begin
          state <= ST_DONE;
          if ((op_r == OP_ADD) || (op_r == OP_SUB)) begin
            res_r <= {{W{1'b0}}, sum[W-1:0]};
            co_r  <= sum[W];
            cy_r  <= ovf_as;
            err_r <= 1'b0;
          end else begin
            res_r <= '0;
            co_r  <= 1'b0;
            cy_r  <= 1'b0;
            err_r <= 1'b1;
          end
        end
        ST_MUL: begin
          if (cnt == CNT_END) begin
            co_r  <= 1'b0;
            cy_r  <= 1'b0;
            err_r <= 1'b0;
            if (post_needed) begin
              state <= ST_POST;
            end else begin
              res_r <= acc;
              state <= ST_DONE;
            end
          end else begin
            cnt   <= cnt + CNT_W'(1);
            if (mplr[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
          end
        end
        ST_DIV: begin
          if (core_done) begin
            co_r <= 1'b0;
            cy_r <= 1'b0;
            if (post_needed) begin
              state <= ST_POST;
            end else begin
              res_r <= div_res;
              err_r <= core_div0 || core_ovf;
              state <= ST_DONE;
            end
          end
        end
`ifdef INT_ALU_SIGNED_EN
        ST_PRE: begin
          neg_p <= a_lo_r[W-1] ^ b_r[W-1];
          neg_q <= a_hi_r[W-1] ^ b_r[W-1];
          neg_r <= a_hi_r[W-1];
          mcand <= {{W{1'b0}}, alo_mag};
          mplr  <= b_mag;
          cnt   <= '0;
          acc   <= '0;
          state <= (op_r == OP_SMUL) ? ST_MUL : ST_DIV;
        end
        ST_POST: begin
          res_r <= sgn_res;
          err_r <= sgn_err;
          state <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_alu_mc.sv
// tb_int_alu_mc: directed table, random ops vs. arithmetic model,
// backpressure hold and mid-operation reset sequences (W=32).
module tb_int_alu_mc;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [63:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] res;
  logic        co;
  logic        cy;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        co;
    logic        cy;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  always #5 clk = ~clk;

  int_alu_mc #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .co        (co),
    .cy        (cy),
    .err       (err)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model written from the arithmetic rules
  task automatic model(input logic [2:0] o, input logic [63:0] x,
                       input logic [31:0] y, output logic [63:0] r,
                       output logic c, output logic v,
                       output logic e, output int l);
    longint sx;
    longint sy;
    longint s;
    logic [32:0] t;
    sx = longint'($signed(x[31:0]));
    sy = longint'($signed(y));
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0; l = 1;
    case (o)
      3'd0: begin
        t = {1'b0, x[31:0]} + {1'b0, y};
        r = {32'b0, t[31:0]};
        c = t[32];
        s = sx + sy;
        v = (s != longint'($signed(s[31:0])));
      end
      3'd1: begin
        r = {32'b0, x[31:0] - y};
        c = (x[31:0] >= y);
        s = sx - sy;
        v = (s != longint'($signed(s[31:0])));
      end
      3'd2: begin
        r = {32'b0, x[31:0]} * {32'b0, y};
        l = 33;
      end
      3'd3, 3'd4: begin
        if (y == 0 || x[63:32] >= y) begin
          e = 1'b1;
          r = (o == 3'd3) ? 64'h0000_0000_FFFF_FFFF : {32'b0, x[31:0]};
        end else begin
          r = (o == 3'd3) ? x / {32'b0, y} : x % {32'b0, y};
          l = 33;
        end
      end
      default: e = 1'b1;
    endcase
  endtask

  // called #1 after a rising edge with the ALU idle
  task automatic issue(input logic [2:0] o, input logic [63:0] x,
                       input logic [31:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    a = {$urandom, $urandom};
    b = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [2:0] o,
                         input logic [63:0] x, input logic [31:0] y,
                         input logic [63:0] er, input logic ec,
                         input logic ev, input logic ee, input int el);
    int lat;
    chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    issue(o, x, y);
    wait_done(lat);
    chk({nm, ".lat"}, 64'(lat), 64'(el));
    chk({nm, ".res"}, res, er);
    chk({nm, ".co"}, 64'(co), 64'(ec));
    chk({nm, ".cy"}, 64'(cy), 64'(ev));
    chk({nm, ".err"}, 64'(err), 64'(ee));
    release_out();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] er;
    logic        ec, ev, ee;
    int          el, lat;
    logic [2:0]  o;
    logic [63:0] x;
    logic [31:0] y, hi;

    tbl[0]  = '{3'd0, 64'hFFFF_FFFF, 32'h1, 64'h0, 1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{3'd1, 64'h8000_0000, 32'h1, 64'h7FFF_FFFF,
                1'b1, 1'b1, 1'b0, 1};
    tbl[2]  = '{3'd2, 64'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 1'b0, 33};
    tbl[3]  = '{3'd3, 64'h1_0000_0000, 32'h2, 64'h8000_0000,
                1'b0, 1'b0, 1'b0, 33};
    tbl[4]  = '{3'd4, 64'd100, 32'd7, 64'd2, 1'b0, 1'b0, 1'b0, 33};
    tbl[5]  = '{3'd3, 64'd5, 32'd0, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1};
    tbl[6]  = '{3'd3, 64'h2_0000_0000, 32'd1, 64'hFFFF_FFFF,
                1'b0, 1'b0, 1'b1, 1};
    tbl[7]  = '{3'd4, 64'h2A, 32'd0, 64'h2A, 1'b0, 1'b0, 1'b1, 1};
    tbl[8]  = '{3'd0, 64'h7FFF_FFFF, 32'h1, 64'h8000_0000,
                1'b0, 1'b1, 1'b0, 1};
    tbl[9]  = '{3'd1, 64'd5, 32'd7, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1};
    tbl[10] = '{3'd5, 64'd3, 32'd4, 64'h0, 1'b0, 1'b0, 1'b1, 1};
    tbl[11] = '{3'd3, 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.res", res, 64'd0);
    chk("rst.flags", {61'd0, co, cy, err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i]) begin
      run_one($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
              tbl[i].res, tbl[i].co, tbl[i].cy, tbl[i].err, tbl[i].lat);
    end

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = '0;
      if (o == 3'd3 || o == 3'd4) begin
        hi = ($urandom_range(0, 3) == 0 || y == 0) ? $urandom
                                                   : $urandom % y;
        x = {hi, $urandom};
      end else begin
        x = {$urandom, $urandom};
      end
      model(o, x, y, er, ec, ev, ee, el);
      run_one($sformatf("rnd%0d", i), o, x, y, er, ec, ev, ee, el);
    end

    issue(3'd2, 64'h1234, 32'h10);
    chk("hold.busy_in_ready", 64'(in_ready), 64'd0);
    wait_done(lat);
    chk("hold.lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold.res", res, 64'h12340);
      chk("hold.out_valid", 64'(out_valid), 64'd1);
      chk("hold.in_ready", 64'(in_ready), 64'd0);
    end
    release_out();

    issue(3'd2, 64'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.res", res, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.idle_valid", 64'(out_valid), 64'd0);
    run_one("post_rst", 3'd0, 64'd2, 32'd3, 64'd5, 1'b0, 1'b0, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
